// File: rtl/au_pkg.sv
// au_pkg: shared constants and types for the arithmetic unit.
//   DATA_WIDTH / MODE_WIDTH : operand and mode widths
//   OPC_*                   : opcodes shared with the instruction-set header
//   AU_*                    : unit mode encodings (opcode with immediate bit cleared)
//   div_state_e             : divider state (IDLE, RUN)
package au_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned MODE_WIDTH   = 4;
    localparam int unsigned OPCODE_WIDTH = MODE_WIDTH;

    // Opcodes; bit0 is the immediate flag.
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADD   = 4'b1000;
    localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI  = 4'b1001;
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUB   = 4'b1010;
    localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI  = 4'b1011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_MULT  = 4'b1100;
    localparam logic [OPCODE_WIDTH-1:0] OPC_MULTI = 4'b1101;
    localparam logic [OPCODE_WIDTH-1:0] OPC_DIV   = 4'b1110;
    localparam logic [OPCODE_WIDTH-1:0] OPC_DIVI  = 4'b1111;

    localparam logic [MODE_WIDTH-1:0] AU_ADD  = OPC_ADD;
    localparam logic [MODE_WIDTH-1:0] AU_SUB  = OPC_SUB;
    localparam logic [MODE_WIDTH-1:0] AU_MULT = OPC_MULT;
    localparam logic [MODE_WIDTH-1:0] AU_DIV  = OPC_DIV;

    typedef enum logic {
        IDLE,
        RUN
    } div_state_e;

endpackage

// File: rtl/au_divider.sv
// au_divider: iterative restoring unsigned divider, one quotient bit per cycle.
//   clk, rst     : clock, asynchronous active-high reset (aborts a division)
//   start_i      : load dividend_i / divisor_i and begin (only honoured when idle)
//   dividend_i   : dividend
//   divisor_i    : divisor
//   busy_o       : division in progress
//   done_o       : the final iteration happens on the coming edge
//   quotient_o   : quotient valid while done_o is high
// A zero divisor yields an all-ones quotient naturally (every trial subtraction fits).
module au_divider
    import au_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    div_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic                  fits;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quo_step;
    logic                  unused_trial_msb;

    // Shift the next dividend bit into the partial remainder and try the subtraction.
    assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign fits     = (shifted >= {1'b0, dvs_q});
    // When the trial fails the shifted remainder is below the divisor, so its MSB is 0.
    assign rem_step = fits ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign quo_step = {quo_q[DATA_WIDTH-2:0], fits};
    assign unused_trial_msb = trial[DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        done_o     = 1'b0;
        quotient_o = quo_step;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = '0;
                    quo_d   = dividend_i;
                    dvs_d   = divisor_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign busy_o = (state_q == RUN);

endmodule

// File: rtl/arith_unit.sv
// arith_unit: clocked ADD/SUB/MULT/DIV unit of the co-processor execution datapath.
//   clk, rst   : clock, asynchronous active-high reset
//   op_en      : issue request, accepted when the unit is not busy
//   mode       : operation select (bit0 = immediate flag, ignored)
//   in1, in2   : unsigned operands, latched at acceptance
//   out        : registered result, held until the next completion
//   busy       : divide in progress, op_en ignored
//   done       : one-cycle pulse, out valid
//   zf, cf, vf : result flags, present only when AU_FLAGS_EN is defined
// ADD/SUB/MULT complete one edge after acceptance; DIV completes 17 edges after.
module arith_unit
    import au_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_en,
    input  logic [MODE_WIDTH-1:0] mode,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy,
    output logic                  done
`ifdef AU_FLAGS_EN
    ,
    output logic                  zf,
    output logic                  cf,
    output logic                  vf
`endif
);

    localparam int unsigned Msb = DATA_WIDTH - 1;

    logic                  valid_q;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  div_pending;
    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quo;

    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH:0]     dif_ext;
    logic [2*DATA_WIDTH-1:0] prod_full;
    logic                    unused_mode_lsb;

    assign unused_mode_lsb = mode[0];

    // A latched DIV waits one cycle before the divider raises busy; block issue then too.
    assign div_pending = valid_q && (mode_q == AU_DIV);
    assign accept      = op_en && !div_busy && !div_pending;

    assign mode_d = accept ? {mode[MODE_WIDTH-1:1], 1'b0} : mode_q;
    assign a_d    = accept ? in1 : a_q;
    assign b_d    = accept ? in2 : b_q;

    assign sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    assign dif_ext   = {1'b0, a_q} - {1'b0, b_q};
    assign prod_full = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};

`ifdef AU_FLAGS_EN
    logic zf_q, zf_d;
    logic cf_q, cf_d;
    logic vf_q, vf_d;
`else
    logic unused_high;
    assign unused_high = ^{sum_ext[DATA_WIDTH], dif_ext[DATA_WIDTH],
                           prod_full[2*DATA_WIDTH-1:DATA_WIDTH]};
`endif

    au_divider u_divider (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_pending),
        .dividend_i (a_q),
        .divisor_i  (b_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_comb begin
        out_d  = out_q;
        done_d = 1'b0;
`ifdef AU_FLAGS_EN
        zf_d = zf_q;
        cf_d = cf_q;
        vf_d = vf_q;
`endif
        if (div_done) begin
            out_d  = div_quo;
            done_d = 1'b1;
`ifdef AU_FLAGS_EN
            zf_d = (div_quo == '0);
            cf_d = (b_q == '0);
            vf_d = 1'b0;
`endif
        end else if (valid_q && !div_pending) begin
            // Non-arithmetic modes complete without touching out or flags.
            done_d = 1'b1;
            case (mode_q)
                AU_ADD: begin
                    out_d = sum_ext[Msb:0];
`ifdef AU_FLAGS_EN
                    zf_d = (sum_ext[Msb:0] == '0);
                    cf_d = sum_ext[DATA_WIDTH];
                    vf_d = (a_q[Msb] == b_q[Msb]) && (sum_ext[Msb] != a_q[Msb]);
`endif
                end
                AU_SUB: begin
                    out_d = dif_ext[Msb:0];
`ifdef AU_FLAGS_EN
                    zf_d = (dif_ext[Msb:0] == '0);
                    cf_d = dif_ext[DATA_WIDTH];
                    vf_d = (a_q[Msb] != b_q[Msb]) && (dif_ext[Msb] != a_q[Msb]);
`endif
                end
                AU_MULT: begin
                    out_d = prod_full[Msb:0];
`ifdef AU_FLAGS_EN
                    zf_d = (prod_full[Msb:0] == '0);
                    cf_d = (prod_full[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
                    vf_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

`ifdef AU_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q <= 1'b0;
            cf_q <= 1'b0;
            vf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            cf_q <= cf_d;
            vf_q <= vf_d;
        end
    end

    assign zf = zf_q;
    assign cf = cf_q;
    assign vf = vf_q;
`endif

    assign out  = out_q;
    assign done = done_q;
    assign busy = div_busy;

endmodule

// File: tb/tb_arith_unit.sv
module tb_arith_unit;

    logic        clk;
    logic        rst;
    logic        op_en;
    logic [3:0]  mode;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [15:0] out;
    logic        busy;
    logic        done;
`ifdef AU_FLAGS_EN
    logic        zf;
    logic        cf;
    logic        vf;
`endif

    arith_unit dut (
        .clk   (clk),
        .rst   (rst),
        .op_en (op_en),
        .mode  (mode),
        .in1   (in1),
        .in2   (in2),
        .out   (out),
        .busy  (busy),
        .done  (done)
`ifdef AU_FLAGS_EN
        ,
        .zf    (zf),
        .cf    (cf),
        .vf    (vf)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        zf;
        logic        cf;
        logic        vf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_issued = 0;
    int   n_done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every done pulse, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 out=%h expected no done", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".out"}, out, e.out);
`ifdef AU_FLAGS_EN
                check({e.name, ".zf"}, {15'b0, zf}, {15'b0, e.zf});
                check({e.name, ".cf"}, {15'b0, cf}, {15'b0, e.cf});
                check({e.name, ".vf"}, {15'b0, vf}, {15'b0, e.vf});
`endif
            end
        end
    end

    // Drive one request for a cycle; operands are scrambled afterwards to prove latching.
    task automatic issue(input string name, input logic [3:0] m, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eo, input logic ez,
                         input logic ec, input logic ev, input bit push);
        exp_t e;
        @(negedge clk);
        op_en = 1'b1;
        mode  = m;
        in1   = a;
        in2   = b;
        if (push) begin
            e.name = name;
            e.out  = eo;
            e.zf   = ez;
            e.cf   = ec;
            e.vf   = ev;
            sb.push_back(e);
            n_issued++;
        end
        @(negedge clk);
        op_en = 1'b0;
        mode  = 4'($urandom);
        in1   = 16'($urandom);
        in2   = 16'($urandom);
    endtask

    // Called right after a DIV issue: busy must rise a cycle late and last 16 cycles.
    task automatic check_div_busy(input string name);
        int cnt;
        cnt = 0;
        check({name, ".busy_lag"}, {15'b0, busy}, 16'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
        check({name, ".busy_cycles"}, 16'(cnt), 16'd16);
        check({name, ".done_at_end"}, {15'b0, done}, 16'd1);
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (sb.size() == 0 && busy === 1'b0) break;
            @(negedge clk);
        end
        if (i == 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got %0d pending expected 0", name, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        op_en = 1'b0;
        mode  = 4'h0;
        in1   = 16'h0;
        in2   = 16'h0;
        repeat (3) @(negedge clk);
        check("reset.out", out, 16'h0000);
        check("reset.busy", {15'b0, busy}, 16'd0);
        check("reset.done", {15'b0, done}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        //     name        mode     in1       in2       out       zf    cf    vf
        issue("add",      4'b1000, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 1);
        issue("sub",      4'b1010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1);
        issue("mult",     4'b1100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        issue("add_wrap", 4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        issue("add_ovf",  4'b1001, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1);
        issue("sub_ovf",  4'b1011, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1);
        issue("multi",    4'b1101, 16'h1234, 16'h0010, 16'h2340, 1'b0, 1'b1, 1'b0, 1);
        issue("nop_hold", 4'b0011, 16'hAAAA, 16'h5555, 16'h2340, 1'b0, 1'b1, 1'b0, 1);
        wait_drain("alu");

        issue("div", 4'b1110, 16'd100, 16'd7, 16'd14, 1'b0, 1'b0, 1'b0, 1);
        check_div_busy("div");
        issue("div0", 4'b1110, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1);
        check_div_busy("div0");
        issue("divi_max", 4'b1111, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1);
        check_div_busy("divi_max");
        issue("div_small", 4'b1110, 16'd5, 16'd9, 16'd0, 1'b1, 1'b0, 1'b0, 1);
        wait_drain("div_small");

        // An ADD pulsed while busy must vanish without a done.
        issue("div_ign", 4'b1110, 16'd1000, 16'd10, 16'd100, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        issue("ign_add", 4'b1000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        wait_drain("div_ign");
        repeat (3) @(negedge clk);

        // Reset mid-divide aborts with no completion.
        issue("div_abort", 4'b1110, 16'd500, 16'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.out", out, 16'h0000);
        check("abort.busy", {15'b0, busy}, 16'd0);
        check("abort.done", {15'b0, done}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue("add_after", 4'b1000, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1);
        wait_drain("add_after");

        check("done_count", 16'(n_done), 16'(n_issued));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
